// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RV32I control path.
// Holds the FSM state encoding, base opcodes, immediate-format codes and the
// select encodings for ALUOp, ALUSrcA/B and ResultSrc.
package riscv_ctrl_pkg;

    // FSM state encoding (4-bit, 15 states used)
    typedef logic [3:0] state_t;

    localparam state_t StFetch    = 4'd0;
    localparam state_t StDecode   = 4'd1;
    localparam state_t StMemAdr   = 4'd2;
    localparam state_t StMemRead  = 4'd3;
    localparam state_t StMemWb    = 4'd4;
    localparam state_t StMemWrite = 4'd5;
    localparam state_t StExecR    = 4'd6;
    localparam state_t StExecI    = 4'd7;
    localparam state_t StAluWb    = 4'd8;
    localparam state_t StBranch   = 4'd9;
    localparam state_t StJal      = 4'd10;
    localparam state_t StJalr     = 4'd11;
    localparam state_t StJalrPc   = 4'd12;
    localparam state_t StLui      = 4'd13;
    localparam state_t StAuipc    = 4'd14;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    // Immediate formats
    localparam logic [2:0] ImmI  = 3'b000;
    localparam logic [2:0] ImmS  = 3'b001;
    localparam logic [2:0] ImmB  = 3'b010;
    localparam logic [2:0] ImmU  = 3'b011;
    localparam logic [2:0] ImmJ  = 3'b100;
    localparam logic [2:0] ImmIu = 3'b101;

    // ALU operation class
    localparam logic [1:0] AluOpAdd  = 2'b00;
    localparam logic [1:0] AluOpSub  = 2'b01;
    localparam logic [1:0] AluOpRDec = 2'b10;
    localparam logic [1:0] AluOpIDec = 2'b11;

    // ALU A operand
    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    // ALU B operand
    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    // Result bus source
    localparam logic [1:0] ResAluOut  = 2'b00;
    localparam logic [1:0] ResRdData  = 2'b01;
    localparam logic [1:0] ResAluRslt = 2'b10;

    // Shift-immediate funct3 values use the unsigned I immediate
    function automatic logic is_shift_imm(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-path bundle between the multicycle controller and the datapath /
// unified memory.
//   Datapath/memory -> control: opcode, funct3, branch_taken, mem_ready
//   Control -> datapath/memory: MemReq, MemWrite, AdrSrc, IRWrite, PCWrite,
//     RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmS, IllegalInstr
// The controller uses the master modport, the datapath side the slave modport.
interface multicycle_control_if;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       branch_taken;
    logic       mem_ready;

    logic       MemReq;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [2:0] ImmS;
    logic       IllegalInstr;

    modport master (
        input  opcode, funct3, branch_taken, mem_ready,
        output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmS, IllegalInstr
    );

    modport slave (
        output opcode, funct3, branch_taken, mem_ready,
        input  MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmS, IllegalInstr
    );

endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RV32I core.
// Sequences FETCH / DECODE / execute / memory / writeback over the shared
// datapath and drives all select lines, write strobes and the immediate format.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; forces every output to 0 while high
//   ctrl : multicycle_control_if.master (instruction fields, branch result,
//          memory ready in; datapath selects and strobes out)
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_if.master       ctrl
);

    state_t state_q, state_d;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_s;
    logic       illegal_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:    if (ctrl.mem_ready) state_d = StDecode;
            StDecode: begin
                case (ctrl.opcode)
                    OpLoad,
                    OpStore:  state_d = StMemAdr;
                    OpRType:  state_d = StExecR;
                    OpIType:  state_d = StExecI;
                    OpBranch: state_d = StBranch;
                    OpJal:    state_d = StJal;
                    OpJalr:   state_d = StJalr;
                    OpLui:    state_d = StLui;
                    OpAuipc:  state_d = StAuipc;
                    default:  state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (ctrl.opcode == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  if (ctrl.mem_ready) state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: if (ctrl.mem_ready) state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalr:     state_d = StJalrPc;
            StJalrPc:   state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StAuipc:    state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    // Output decode; reset overrides so an abandoned request never strobes
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = ResAluOut;
        alu_src_a     = SrcAPc;
        alu_src_b     = SrcBRs2;
        alu_op        = AluOpAdd;
        imm_s         = ImmI;
        illegal_instr = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    mem_req    = 1'b1;
                    adr_src    = 1'b0;
                    ir_write   = ctrl.mem_ready;
                    pc_write   = ctrl.mem_ready;
                    alu_src_a  = SrcAPc;
                    alu_src_b  = SrcBFour;
                    alu_op     = AluOpAdd;
                    result_src = ResAluRslt;
                end
                StDecode: begin
                    alu_src_a = SrcAOldPc;
                    alu_src_b = SrcBImm;
                    alu_op    = AluOpAdd;
                    // Branch target precomputed in DECODE, except JAL's J-type target
                    imm_s     = (ctrl.opcode == OpJal) ? ImmJ : ImmB;
                    case (ctrl.opcode)
                        OpLoad, OpStore, OpRType, OpIType, OpBranch,
                        OpJal, OpJalr, OpLui, OpAuipc: illegal_instr = 1'b0;
                        default:                       illegal_instr = 1'b1;
                    endcase
                end
                StMemAdr: begin
                    alu_src_a = SrcARs1;
                    alu_src_b = SrcBImm;
                    alu_op    = AluOpAdd;
                    imm_s     = (ctrl.opcode == OpStore) ? ImmS : ImmI;
                end
                StMemRead: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                StMemWb: begin
                    result_src = ResRdData;
                    reg_write  = 1'b1;
                end
                StMemWrite: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                StExecR: begin
                    alu_src_a = SrcARs1;
                    alu_src_b = SrcBRs2;
                    alu_op    = AluOpRDec;
                end
                StExecI: begin
                    alu_src_a = SrcARs1;
                    alu_src_b = SrcBImm;
                    alu_op    = AluOpIDec;
                    imm_s     = is_shift_imm(ctrl.funct3) ? ImmIu : ImmI;
                end
                StAluWb: begin
                    result_src = ResAluOut;
                    reg_write  = 1'b1;
                end
                StBranch: begin
                    alu_src_a  = SrcARs1;
                    alu_src_b  = SrcBRs2;
                    alu_op     = AluOpSub;
                    result_src = ResAluOut;
                    pc_write   = ctrl.branch_taken;
                end
                StJal: begin
                    pc_write   = 1'b1;
                    result_src = ResAluOut;
                    alu_src_a  = SrcAOldPc;
                    alu_src_b  = SrcBFour;
                    alu_op     = AluOpAdd;
                end
                StJalr: begin
                    alu_src_a = SrcARs1;
                    alu_src_b = SrcBImm;
                    imm_s     = ImmI;
                    alu_op    = AluOpAdd;
                end
                StJalrPc: begin
                    pc_write   = 1'b1;
                    result_src = ResAluOut;
                    alu_src_a  = SrcAOldPc;
                    alu_src_b  = SrcBFour;
                end
                StLui: begin
                    alu_src_a = SrcAZero;
                    alu_src_b = SrcBImm;
                    imm_s     = ImmU;
                    alu_op    = AluOpAdd;
                end
                StAuipc: begin
                    alu_src_a = SrcAOldPc;
                    alu_src_b = SrcBImm;
                    imm_s     = ImmU;
                    alu_op    = AluOpAdd;
                end
                default: ;
            endcase
        end
    end

    assign ctrl.MemReq       = mem_req;
    assign ctrl.MemWrite     = mem_write;
    assign ctrl.AdrSrc       = adr_src;
    assign ctrl.IRWrite      = ir_write;
    assign ctrl.PCWrite      = pc_write;
    assign ctrl.RegWrite     = reg_write;
    assign ctrl.ResultSrc    = result_src;
    assign ctrl.ALUSrcA      = alu_src_a;
    assign ctrl.ALUSrcB      = alu_src_b;
    assign ctrl.ALUOp        = alu_op;
    assign ctrl.ImmS         = imm_s;
    assign ctrl.IllegalInstr = illegal_instr;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control. The reference model
// expands each instruction into a queue of expected per-cycle output vectors
// (by instruction class), consuming memory-wait steps only on mem_ready.
module tb_multicycle_control;

    logic clk;
    logic rst;

    multicycle_control_if bus_if ();

    multicycle_control dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;

    // Output vector: MemReq MemWrite AdrSrc IRWrite PCWrite RegWrite
    //                ResultSrc[2] ALUSrcA[2] ALUSrcB[2] ALUOp[2] ImmS[3] IllegalInstr
    typedef struct {
        string       name;
        logic [17:0] vec;
        bit          wait_ready;  // stays until mem_ready
        bit          gate_ready;  // IRWrite/PCWrite follow mem_ready
        bit          gate_taken;  // PCWrite follows branch_taken
    } step_t;

    step_t q[$];

    function automatic logic [17:0] outv(input bit mreq, input bit mwr, input bit adr,
                                         input bit irw, input bit pcw, input bit rw,
                                         input logic [1:0] res, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] op,
                                         input logic [2:0] imm, input bit ill);
        return {mreq, mwr, adr, irw, pcw, rw, res, a, b, op, imm, ill};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {bus_if.MemReq, bus_if.MemWrite, bus_if.AdrSrc, bus_if.IRWrite,
                bus_if.PCWrite, bus_if.RegWrite, bus_if.ResultSrc, bus_if.ALUSrcA,
                bus_if.ALUSrcB, bus_if.ALUOp, bus_if.ImmS, bus_if.IllegalInstr};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input string n, input logic [17:0] v, input bit w = 0,
                        input bit gr = 0, input bit gt = 0);
        step_t s;
        s.name = n; s.vec = v; s.wait_ready = w; s.gate_ready = gr; s.gate_taken = gt;
        q.push_back(s);
    endtask

    // Expected cycle sequence of one whole instruction
    task automatic start_instr(input logic [6:0] op, input logic [2:0] f3);
        bit legal;
        bus_if.opcode = op;
        bus_if.funct3 = f3;
        legal = (op == 7'b0000011) || (op == 7'b0100011) || (op == 7'b0110011) ||
                (op == 7'b0010011) || (op == 7'b1100011) || (op == 7'b1101111) ||
                (op == 7'b1100111) || (op == 7'b0110111) || (op == 7'b0010111);
        push("fetch", outv(1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 0), 1, 1, 0);
        push("decode", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0,
                            (op == 7'b1101111) ? 3'd4 : 3'd2, !legal));
        case (op)
            7'b0000011: begin
                push("memadr_ld", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 3'd0, 0));
                push("memread", outv(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0), 1);
                push("memwb", outv(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b0100011: begin
                push("memadr_st", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 3'd1, 0));
                push("memwrite", outv(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0), 1);
            end
            7'b0110011: begin
                push("execr", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd2, 3'd0, 0));
                push("aluwb", outv(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b0010011: begin
                push("execi", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd3,
                                   (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0, 0));
                push("aluwb", outv(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b1100011: begin
                push("branch", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd1, 3'd0, 0), 0, 0, 1);
            end
            7'b1101111: begin
                push("jal", outv(0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 2'd0, 3'd0, 0));
                push("aluwb", outv(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b1100111: begin
                push("jalr", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, 3'd0, 0));
                push("jalrpc", outv(0, 0, 0, 0, 1, 0, 2'd0, 2'd1, 2'd2, 2'd0, 3'd0, 0));
                push("aluwb", outv(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b0110111: begin
                push("lui", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd1, 2'd0, 3'd3, 0));
                push("aluwb", outv(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b0010111: begin
                push("auipc", outv(0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 2'd0, 3'd3, 0));
                push("aluwb", outv(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            default: ;
        endcase
    endtask

    task automatic start_random();
        logic [6:0] ops [11];
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111,
                7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000, 7'b0000000};
        ops[10] = 7'($urandom);
        start_instr(ops[$urandom_range(0, 10)], 3'($urandom));
    endtask

    // One clock cycle: drive inputs, check on the falling edge, advance model
    task automatic do_cycle(input logic r, input logic rdy, input logic bt);
        logic [17:0] exp;
        string       n;
        if (q.size() == 0) start_random();
        rst                 = r;
        bus_if.mem_ready    = rdy;
        bus_if.branch_taken = bt;
        @(negedge clk);
        if (r) begin
            exp = '0;
            n   = "reset";
        end else begin
            exp = q[0].vec;
            n   = q[0].name;
            if (q[0].gate_ready) begin
                exp[14] = rdy;
                exp[13] = rdy;
            end
            if (q[0].gate_taken) exp[13] = bt;
        end
        check_eq($sformatf("%s@%0d", n, cyc), 32'(dut_vec()), 32'(exp));
        @(posedge clk);
        cyc++;
        if (r) q.delete();
        else if (!(q[0].wait_ready && !rdy)) void'(q.pop_front());
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst                 = 1'b1;
        bus_if.opcode       = '0;
        bus_if.funct3       = '0;
        bus_if.mem_ready    = 1'b0;
        bus_if.branch_taken = 1'b0;

        do_cycle(1, 1, 1);
        do_cycle(1, 0, 0);

        // R-type, zero-wait memory
        start_instr(7'b0110011, 3'd0);
        repeat (4) do_cycle(0, 1, 0);

        // Load with two wait cycles in MEMREAD
        start_instr(7'b0000011, 3'd2);
        do_cycle(0, 1, 0); do_cycle(0, 1, 0); do_cycle(0, 1, 0);
        do_cycle(0, 0, 0); do_cycle(0, 0, 0); do_cycle(0, 1, 0); do_cycle(0, 1, 0);

        // Branch taken then not taken
        start_instr(7'b1100011, 3'd0);
        repeat (3) do_cycle(0, 1, 1);
        start_instr(7'b1100011, 3'd1);
        repeat (3) do_cycle(0, 1, 0);

        // JALR, illegal opcode, shift immediate
        start_instr(7'b1100111, 3'd0);
        repeat (5) do_cycle(0, 1, 0);
        start_instr(7'b0000000, 3'd0);
        repeat (2) do_cycle(0, 1, 0);
        start_instr(7'b0010011, 3'd5);
        repeat (4) do_cycle(0, 1, 0);

        // Reset during a MEMWRITE wait
        start_instr(7'b0100011, 3'd2);
        repeat (3) do_cycle(0, 1, 0);
        do_cycle(0, 0, 0);
        rst = 1'b1;
        #1;
        check_eq("memwrite_drop", 32'(bus_if.MemWrite), 32'd0);
        check_eq("memreq_drop", 32'(bus_if.MemReq), 32'd0);
        do_cycle(1, 0, 0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_memreq", 32'(bus_if.MemReq), 32'd1);
        check_eq("post_rst_adrsrc", 32'(bus_if.AdrSrc), 32'd0);
        do_cycle(0, 0, 0);

        // Randomized traffic with occasional resets
        repeat (3000) begin
            do_cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                     1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences fetch, decode, execute, memory and writeback over shared PC, instruction, ALU and memory resources. Per state, it drives the datapath select lines, the write strobes and the immediate-format select `ImmS` into the immediate extender. It handles one instruction at a time and uses a ready handshake with the unified instruction/data memory.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `branch_taken` in 1: condition result from the external branch comparator, valid in BRANCH.
- `mem_ready` in 1: memory completed the current request this cycle.
- `MemReq` out 1: memory request, held until `mem_ready`.
- `MemWrite` out 1: the request is a write.
- `AdrSrc` out 1: memory address source, 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: load the instruction register and OldPC.
- `PCWrite` out 1: load PC from the result bus.
- `RegWrite` out 1: register-file write.
- `ResultSrc` out 2: result bus source, 00 = ALUOut, 01 = read data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A operand, 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- `ALUSrcB` out 2: ALU B operand, 00 = rs2, 01 = ImmExt, 10 = constant 4.
- `ALUOp` out 2: ALU operation class, 00 = add, 01 = sub, 10 = R-decode, 11 = I-decode.
- `ImmS` out 3: immediate format, 000 I, 001 S, 010 B, 011 U, 100 J, 101 I-unsigned.
- `IllegalInstr` out 1: one-cycle pulse on an unrecognised opcode.

## Operation
- 4-bit state register with 15 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRPC, LUI, AUIPC.
- All outputs are Moore decodes of the state, except for these handshake- and condition-qualified strobes:
  - `PCWrite` in FETCH is gated by `mem_ready`; in BRANCH it equals `branch_taken`.
  - `IRWrite` in FETCH is gated by `mem_ready`.
- Any output not listed for a state is 0.
- **FETCH:** `MemReq`=1, `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10. On `mem_ready`, go to DECODE; otherwise stay.
- **DECODE:** `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00. `ImmS`=100 when opcode is 1101111, else 010. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → FETCH, with `IllegalInstr`=1 for that cycle.
- **MEMADR:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00. `ImmS`=001 for a store, else 000. Next state is MEMWRITE for a store, else MEMREAD.
- **MEMREAD:** `MemReq`=1, `AdrSrc`=1. On `mem_ready` go to MEMWB.
- **MEMWB:** `ResultSrc`=01, `RegWrite`=1. Next state FETCH.
- **MEMWRITE:** `MemReq`=1, `MemWrite`=1, `AdrSrc`=1. On `mem_ready` go to FETCH.
- **EXECR:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10. Next state ALUWB.
- **EXECI:** `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=11. `ImmS`=101 when `funct3` is 001 or 101 (shifts), else 000. Next state ALUWB.
- **ALUWB:** `ResultSrc`=00, `RegWrite`=1. Next state FETCH.
- **BRANCH:** `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00. Next state FETCH.
- **JAL:** `PCWrite`=1, `ResultSrc`=00, `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00. Next state ALUWB.
- **JALR:** `ALUSrcA`=10, `ALUSrcB`=01, `ImmS`=000, `ALUOp`=00. Next state JALRPC.
- **JALRPC:** `PCWrite`=1, `ResultSrc`=00, `ALUSrcA`=01, `ALUSrcB`=10. Next state ALUWB.
- **LUI:** `ALUSrcA`=11, `ALUSrcB`=01, `ImmS`=011, `ALUOp`=00. Next state ALUWB.
- **AUIPC:** as LUI but `ALUSrcA`=01. Next state ALUWB.

## Timing
- Reset: at the clock edge with `rst`=1, state becomes FETCH. While `rst` is high, every strobe (`MemReq`, `MemWrite`, `IRWrite`, `PCWrite`, `RegWrite`, `IllegalInstr`) is forced to 0. Select outputs reset to 0.
- Reset mid-operation: an in-flight memory request is abandoned with no write strobe. The first `MemReq` appears in the cycle after `rst` falls.
- Cycles per instruction with zero-wait memory:
  - branch: 3
  - R, I, store, LUI, AUIPC, JAL: 4
  - load, JALR: 5
- Each memory wait cycle adds one cycle in FETCH, MEMREAD or MEMWRITE.
- `MemReq` and address selects are stable throughout a wait. `mem_ready` is ignored in states that have no request.
- `funct3` and `opcode` are sampled only in DECODE, MEMADR and EXECI. The IR is stable from the FETCH handshake cycle onward.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum
  - opcode constants
  - `ImmS` codes
  - the `ALUOp`, `ALUSrcA/B` and `ResultSrc` encodings
- The ALU function decoder (funct3/funct7 → ALU control) stays in a separate existing module.
- Natural sub-module: none. This is a single FSM file with next-state and output decode in separate always blocks.

## Test plan
- **R-type, zero-wait memory** (opcode 0110011, `mem_ready`=1): states FETCH, DECODE, EXECR, ALUWB. `RegWrite`=1 only in cycle 4; `IRWrite`=1 only in cycle 1.
- **Load with memory wait** (opcode 0000011, `mem_ready` low for 2 cycles in MEMREAD): `MemReq`=1 and `AdrSrc`=1 held for 3 cycles, then MEMWB with `ResultSrc`=01. Total 7 cycles.
- **Branch taken and not taken** (opcode 1100011, `branch_taken`=1 then 0): `PCWrite`=1 in BRANCH only for the taken case. `ImmS`=010 in DECODE. 3 cycles each.
- **JALR** (opcode 1100111): sequence JALR, JALRPC, ALUWB. `PCWrite` in JALRPC with `ResultSrc`=00; `RegWrite` in ALUWB.
- **Illegal opcode** (0000000): `IllegalInstr` pulses in DECODE, next state FETCH, no `RegWrite`/`MemWrite`/`PCWrite` in DECODE.
- **Reset during a MEMWRITE wait**: `MemWrite` drops to 0 at once. The cycle after `rst` falls shows FETCH with `MemReq`=1 and `AdrSrc`=0.
